icache_assoc: RTL
=================

// Module: icache_assoc
// PURPOSE
//  Set-associative, multi-word-line instruction cache between core fetch and AHB-Lite master port.
//  Next-generation I-cache: parametrised ways, burst line refill, round-robin replacement, flush, bus-error reporting.
//  Read-only; one outstanding request; HWRITE tied low.
// PARAMETERS
//  CACHE_SIZE  1024  total data capacity, bytes (power of 2)
//  LINE_SIZE   32    line size, bytes; legal 16/32/64 (WORDS = LINE_SIZE/4)
//  WAYS        2     associativity; legal 1/2/4/8; SETS = CACHE_SIZE/(LINE_SIZE*WAYS) >= 2
// PORTS
//  clk         in   1   single clock, all flops on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  req_valid   in   1   fetch request
//  req_addr    in   32  byte address; bits[1:0] ignored
//  req_ready   out  1   request accepted when req_valid && req_ready
//  resp_valid  out  1   one-cycle response pulse
//  resp_rdata  out  32  instruction word
//  resp_hit    out  1   1 = hit, 0 = filled by refill
//  resp_err    out  1   bus error on refill; resp_rdata = 0
//  flush       in   1   invalidate all lines (pulse)
//  HADDR out 32, HTRANS out 2, HBURST out 3, HSIZE out 3 (=3'b010), HWRITE out 1 (=0), HWDATA out 32 (=0)
//  HRDATA in 32, HREADY in 1, HRESP in 1   AHB-Lite master signals
// BEHAVIOUR
//  Address split: offset = [log2(LINE_SIZE)-1:0], index = next log2(SETS) bits, tag = rest.
//  Reset: all valid bits 0, victim pointers 0, state IDLE, req_ready 1, resp_* 0, HTRANS IDLE, HADDR 0.
//  FSM IDLE -> LOOKUP -> (IDLE | REFILL -> RESP -> IDLE). req_ready = 1 only in IDLE with no flush.
//  IDLE: accepted request registers addr -> LOOKUP next cycle.
//  LOOKUP: compare tag in all ways of set; hit -> resp_valid=1, resp_hit=1, word = offset[..:2];
//   back to IDLE (hit latency 1 cycle after acceptance, throughput 1 per 2 cycles). Miss -> REFILL.
//  Victim: first invalid way (lowest index); else per-set round-robin pointer, advanced only on install.
//  REFILL: INCR burst from line-aligned address, words 0..WORDS-1 in order.
//   HBURST = INCR4/INCR8/INCR16 for WORDS 4/8/16. Beat 0 NONSEQ, others SEQ; address advances only when HREADY=1.
//   Pipelined: data of beat k sampled when HREADY=1 during address phase of k+1; HTRANS=IDLE after last address.
//   Each data word written into victim way as it arrives; victim valid cleared at refill start.
//  RESP: after last beat, victim tag written, valid set, resp_valid=1, resp_hit=0, word of requested offset -> IDLE.
//  Error: HRESP=1 during data phase -> HTRANS IDLE next cycle, remaining beats dropped, line stays invalid,
//   pointer not advanced, resp_valid=1, resp_err=1, resp_rdata=0 -> IDLE.
//  Flush: in IDLE clears all valid bits in 1 cycle; flush and req_valid same cycle -> flush wins, request not accepted.
//   Flush during LOOKUP/REFILL/RESP latched; current access completes normally, flush applied on return to IDLE.
//  resp_rdata/resp_hit/resp_err hold last value between pulses; resp_err is 0 on every non-error response.
//  Reset mid-refill: burst abandoned immediately, HTRANS IDLE, all lines invalid.
// TESTING
//  Cold miss 0x0000_0104 (LINE 32, WAYS 2): one INCR8 NONSEQ@0x100 then SEQ to 0x11C -> resp_hit=0, rdata=mem[0x104].
//  Repeat read 0x0000_0108 -> resp_valid one cycle after accept, resp_hit=1, no HTRANS activity.
//  Fill 0x100, 0x500, 0x900 (same set): third evicts way0 (0x100); re-read 0x500 hit, 0x100 miss.
//  HREADY low 3 cycles on beat 2 -> HADDR/HTRANS held stable, all 8 words correct.
//  HRESP=1 on beat 4 -> resp_err=1, rdata=0; re-read same line -> miss and full refill.
//  flush pulse during refill -> request completes, next read of same address misses.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative read-only instruction cache.
// AHB-Lite INCR burst line refill, round-robin victim, flush.
module icache_assoc #(
    parameter int CACHE_SIZE = 1024,
    parameter int LINE_SIZE  = 32,
    parameter int WAYS       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_hit,
    output logic        resp_err,
    input  logic        flush,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int WORDS = LINE_SIZE / 4;
    localparam int SETS  = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int OFF   = $clog2(LINE_SIZE);
    localparam int IW    = $clog2(SETS);
    localparam int WB    = $clog2(WORDS);
    localparam int TW    = 32 - OFF - IW;
    localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CW    = WB + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0] ALL  = CW'(WORDS);
    localparam logic [2:0] BURST =
        (WORDS == 4) ? 3'b011 :
        (WORDS == 8) ? 3'b101 : 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:2]   addr_q;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [WB-1:0] wsel;

    logic [SETS-1:0] valid_q [WAYS];
    logic [VW-1:0]   ptr_q [SETS];
    logic [TW-1:0]   tag_mem [WAYS][SETS];
    logic [31:0]     data_mem [WAYS][SETS*WORDS];

    logic [VW-1:0] victim_q;
    logic          vic_ptr_q;
    logic [CW-1:0] addr_cnt_q;
    logic [CW-1:0] data_cnt_q;
    logic          err_q;
    logic          flush_pend_q;
    logic [31:0]   last_rdata_q;
    logic          last_hit_q;
    logic          last_err_q;

    logic          hit;
    logic [VW-1:0] hit_way;
    logic          inv_found;
    logic [VW-1:0] vic;
    logic          accept;
    logic          do_flush;
    logic          a_act;
    logic          d_act;
    logic          beat_err;
    logic          beat_wr;
    logic          last_beat;
    logic [VW-1:0] rd_way;
    logic [31:0]   rd_word;
    logic          unused_ok;

    assign idx  = addr_q[OFF+IW-1:OFF];
    assign tag  = addr_q[31:OFF+IW];
    assign wsel = addr_q[OFF-1:2];
    assign unused_ok = ^req_addr[1:0];

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = VW'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        vic       = ptr_q[idx];
        inv_found = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) begin
                vic       = VW'(w);
                inv_found = 1'b1;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) && !flush && !flush_pend_q;
    assign accept    = req_valid && req_ready;
    assign do_flush  = (state_q == S_IDLE) && (flush || flush_pend_q);

    assign a_act     = (state_q == S_REFILL) && (addr_cnt_q != ALL);
    assign d_act     = (state_q == S_REFILL) && (data_cnt_q != addr_cnt_q);
    assign beat_err  = d_act && HRESP;
    assign beat_wr   = d_act && HREADY && !HRESP;
    assign last_beat = beat_wr && (data_cnt_q == LAST);

    assign HTRANS = a_act ? ((addr_cnt_q == '0) ? 2'b10 : 2'b11) : 2'b00;
    assign HADDR  = a_act ?
        {addr_q[31:OFF], addr_cnt_q[WB-1:0], 2'b00} : 32'h0;
    assign HBURST = BURST;
    assign HSIZE  = 3'b010;
    assign HWRITE = 1'b0;
    assign HWDATA = 32'h0;

    assign rd_way  = (state_q == S_LOOKUP) ? hit_way : victim_q;
    assign rd_word = data_mem[rd_way][{idx, wsel}];

    assign resp_valid = ((state_q == S_LOOKUP) && hit) ||
                        (state_q == S_RESP);
    assign resp_rdata = !resp_valid ? last_rdata_q :
                        ((state_q == S_RESP) && err_q) ? 32'h0 : rd_word;
    assign resp_hit   = resp_valid ? (state_q == S_LOOKUP) : last_hit_q;
    assign resp_err   = resp_valid ? ((state_q == S_RESP) && err_q)
                                   : last_err_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_IDLE : S_REFILL;
            S_REFILL: if (beat_err || last_beat) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control state: valid bits, pointers, burst counters, held response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            victim_q     <= '0;
            vic_ptr_q    <= 1'b0;
            addr_cnt_q   <= '0;
            data_cnt_q   <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            last_rdata_q <= 32'h0;
            last_hit_q   <= 1'b0;
            last_err_q   <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            if (accept) addr_q <= req_addr[31:2];
            if (state_q != S_IDLE && flush) flush_pend_q <= 1'b1;
            if (do_flush) begin
                flush_pend_q <= 1'b0;
                for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end
            if (resp_valid) begin
                last_rdata_q <= resp_rdata;
                last_hit_q   <= resp_hit;
                last_err_q   <= resp_err;
            end
            if (state_q == S_LOOKUP && !hit) begin
                victim_q         <= vic;
                vic_ptr_q        <= !inv_found;
                addr_cnt_q       <= '0;
                data_cnt_q       <= '0;
                err_q            <= 1'b0;
                valid_q[vic][idx] <= 1'b0;
            end
            if (HREADY && a_act && !beat_err) addr_cnt_q <= addr_cnt_q + 1'b1;
            if (beat_wr) data_cnt_q <= data_cnt_q + 1'b1;
            if (beat_err) err_q <= 1'b1;
            if (state_q == S_RESP && !err_q) begin
                valid_q[victim_q][idx] <= 1'b1;
                if (vic_ptr_q)
                    ptr_q[idx] <= (WAYS == 1) ? '0 : ptr_q[idx] + 1'b1;
            end
        end
    end

    // Line data and tag storage (no reset; guarded by valid bits)
    always_ff @(posedge clk) begin
        if (beat_wr)
            data_mem[victim_q][{idx, data_cnt_q[WB-1:0]}] <= HRDATA;
        if (state_q == S_RESP && !err_q)
            tag_mem[victim_q][idx] <= tag;
    end

endmodule
